imem_boot_responder: RTL and testbench
======================================

Name: imem_boot_responder

Overview:
- Responder end of the CPU instruction-fetch port: takes the CPU's word-addressed fetch `pc` and returns `instr` combinationally in the same cycle, because the IF stage consumes it without a wait state.
- Also the writer side of instruction memory: a byte-stream boot loader fills the array from a host link (UART/debug bridge).
- Holds the CPU in reset until a complete image has been loaded.
- Sits beside CPU_TOP at SoC level, replacing a static IROM.

Parameters:
AW, 14, word-address width; array depth 2**AW words; matches the CPU `pc` width.
NOP_INSTR, 32'h0000_0013, word returned for unloaded or out-of-image addresses (addi x0,x0,0).

Ports:
clk  input  1  system clock; all state on rising edge.
rst_n  input  1  asynchronous active-low reset.
start  input  1  single-cycle pulse; begins a load; honoured only in IDLE, DONE, ERR.
rx_valid  input  1  host byte valid.
rx_data  input  8  host byte.
rx_ready  output  1  loader can accept a byte.
pc  input  AW  CPU fetch word address.
instr  output  32  fetched instruction, combinational from `pc`.
cpu_rst_n  output  1  active-low reset to CPU_TOP; high only in DONE.
load_done  output  1  image loaded successfully.
load_err  output  1  header count exceeded depth.
words_loaded  output  AW+1  words written in the current or last load.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; rx_ready=0, cpu_rst_n=0, load_done=0, load_err=0, words_loaded=0.
  - Byte counter, shift register and word count cleared.
  - instr=NOP_INSTR.
  - Array contents are not reset.
- States: IDLE, HDR, DATA, DONE, ERR.
  - IDLE: start -> HDR.
  - HDR:
    - rx_ready=1. Accepts exactly 4 bytes, little-endian, forming 32-bit count N.
    - On the edge accepting byte 4:
      - N==0 -> DONE.
      - N > 2**AW -> ERR.
      - otherwise -> DATA with word_ptr=0.
  - DATA:
    - rx_ready=1.
    - Every 4 accepted bytes (little-endian; first byte = bits 7:0) form one word, written to mem[word_ptr] on the edge accepting byte 4.
    - Same edge: word_ptr and words_loaded increment.
    - When the written word is word N-1 -> DONE.
  - DONE: rx_ready=0, load_done=1, cpu_rst_n=1. start -> HDR.
  - ERR: rx_ready=0, load_err=1, cpu_rst_n=0. start -> HDR.
- Entering HDR from start: load_done, load_err, words_loaded, byte counter and word_ptr all cleared on the same edge.
- cpu_rst_n is a register, set on the edge entering DONE and cleared on the edge leaving DONE. No glitches.
- Handshake:
  - A byte transfers on a rising edge with rx_valid && rx_ready.
  - rx_valid gaps of any length are legal; partial-word assembly is retained across gaps.
  - rx_data while rx_ready=0 is ignored.
- start behaviour:
  - start in HDR or DATA is ignored; loading is not restarted mid-image.
  - start coincident with a byte in DONE/ERR: the byte is not consumed (rx_ready=0 that cycle).
- Fetch:
  - instr = mem[pc] when state==DONE and pc < words_loaded; otherwise NOP_INSTR.
  - Combinational from `pc`, zero-cycle latency.
  - pc >= words_loaded returns NOP; there is no wrap-around.
  - Any fetch outside DONE returns NOP_INSTR.
- Width rules:
  - N is compared as 32-bit unsigned against 2**AW; N == 2**AW is legal and fills the array.
  - word_ptr is AW+1 bits so that a full image does not wrap.
- Async reset mid-load: immediately IDLE, cpu_rst_n low; partially written words remain in the array but are unreachable, because words_loaded=0.

Test Plan:
1. Reset, start, header 03 00 00 00, words 0x00500093, 0x00100113, 0x002081B3 -> DONE on the 16th byte edge; cpu_rst_n rises that edge; words_loaded=3; pc=0/1/2 return those words; pc=3 returns 0x00000013.
2. Header 00 00 00 00 -> DONE directly after byte 4; words_loaded=0; cpu_rst_n=1; every pc returns NOP.
3. AW=4, header count 17 -> ERR; load_err=1; cpu_rst_n stays 0; rx_ready=0. Then start with count 16 and 16 words -> DONE; pc=15 returns the last word.
4. Random 0–5 cycle gaps in rx_valid during a 2-word load; start pulsed mid-DATA -> ignored; image identical to the gap-free load.
5. Async rst_n low after 6 data bytes of a 2-word load -> same-cycle IDLE, cpu_rst_n=0, words_loaded=0. Reload 1 word 0xDEADBEEF -> pc=0 returns 0xDEADBEEF, pc=1 returns NOP.
6. In DONE, pulse start -> cpu_rst_n falls that edge; load_done=0; instr=NOP for all pc until the new load completes.

Source files
------------

// File: rtl/imem_boot_responder.sv
// Instruction memory with a byte-stream boot loader on the write side and a
// zero-latency fetch port on the read side; holds the CPU in reset until loaded.
module imem_boot_responder #(
  parameter int          AW        = 14,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          rx_valid,
  input  logic [7:0]    rx_data,
  output logic          rx_ready,
  input  logic [AW-1:0] pc,
  output logic [31:0]   instr,
  output logic          cpu_rst_n,
  output logic          load_done,
  output logic          load_err,
  output logic [AW:0]   words_loaded
);

  typedef enum logic [2:0] {IDLE, HDR, DATA, DONE, ERR} state_t;

  localparam logic [32:0] DEPTH   = 33'd1 << AW;
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  state_t       state_q, state_d;
  logic [1:0]   byte_cnt_q;
  logic [23:0]  shift_q;
  logic [AW:0]  word_ptr_q;
  logic [AW:0]  n_words_q;
  logic         cpu_rst_n_q, load_done_q, load_err_q;
  logic [31:0]  mem [2**AW];

  logic         xfer, last_byte, start_load, mem_we;
  logic [31:0]  assembled;

  assign rx_ready  = (state_q == HDR) || (state_q == DATA);
  assign xfer      = rx_valid && rx_ready;
  assign last_byte = xfer && (byte_cnt_q == 2'd3);
  // First byte received lands in bits 7:0 once all four are in.
  assign assembled = {rx_data, shift_q};

  always_comb begin
    state_d    = state_q;
    mem_we     = 1'b0;
    start_load = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = HDR;
          start_load = 1'b1;
        end
      end
      HDR: begin
        if (last_byte) begin
          if (assembled == 32'd0)              state_d = DONE;
          else if ({1'b0, assembled} > DEPTH)  state_d = ERR;
          else                                 state_d = DATA;
        end
      end
      DATA: begin
        if (last_byte) begin
          mem_we = 1'b1;
          if (word_ptr_q + PTR_ONE == n_words_q) state_d = DONE;
        end
      end
      DONE, ERR: begin
        if (start) begin
          state_d    = HDR;
          start_load = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values; mixing in blocking updates creates order-dependent races.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      byte_cnt_q  <= 2'd0;
      shift_q     <= 24'd0;
      word_ptr_q  <= '0;
      n_words_q   <= '0;
      cpu_rst_n_q <= 1'b0;
      load_done_q <= 1'b0;
      load_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      // Status outputs are flops decoded from the next state, so they are glitch-free.
      cpu_rst_n_q <= (state_d == DONE);
      load_done_q <= (state_d == DONE);
      load_err_q  <= (state_d == ERR);
      if (start_load) begin
        byte_cnt_q <= 2'd0;
        word_ptr_q <= '0;
      end else if (xfer) begin
        byte_cnt_q <= byte_cnt_q + 2'd1;
        shift_q    <= {rx_data, shift_q[23:8]};
        if (state_q == HDR && last_byte) n_words_q <= assembled[AW:0];
        if (mem_we)                      word_ptr_q <= word_ptr_q + PTR_ONE;
      end
    end
  end

  // NOTE: the array has no reset; clearing every word would block RAM inference.
  // Stale contents stay unreachable because fetches are gated by words_loaded.
  always_ff @(posedge clk) begin
    if (mem_we) mem[word_ptr_q[AW-1:0]] <= assembled;
  end

  always_comb begin
    instr = NOP_INSTR;
    if (state_q == DONE && {1'b0, pc} < word_ptr_q) instr = mem[pc];
  end

  assign cpu_rst_n    = cpu_rst_n_q;
  assign load_done    = load_done_q;
  assign load_err     = load_err_q;
  assign words_loaded = word_ptr_q;

endmodule

// File: tb/tb_imem_boot_responder.sv
// Directed bench for imem_boot_responder: loads images over the byte stream and
// compares fetched words against a scoreboard queue filled as bytes are sent.
module tb_imem_boot_responder;

  localparam int          AW  = 4;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          rx_valid = 1'b0;
  logic [7:0]    rx_data = 8'h00;
  logic          rx_ready;
  logic [AW-1:0] pc = '0;
  logic [31:0]   instr;
  logic          cpu_rst_n;
  logic          load_done;
  logic          load_err;
  logic [AW:0]   words_loaded;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q [$];

  imem_boot_responder #(.AW(AW), .NOP_INSTR(NOP)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .rx_valid(rx_valid),
    .rx_data(rx_data), .rx_ready(rx_ready), .pc(pc), .instr(instr),
    .cpu_rst_n(cpu_rst_n), .load_done(load_done), .load_err(load_err),
    .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    repeat (gap) @(negedge clk);
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = b;
    for (int i = 0; i < 20 && !rx_ready; i++) @(negedge clk);
    if (!rx_ready) check("rx_ready_timeout", {31'd0, rx_ready}, 32'd1);
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic send_hdr(input logic [31:0] n);
    for (int i = 0; i < 4; i++) send_byte(n[8*i +: 8], 0);
  endtask

  task automatic send_word(input logic [31:0] w, input int max_gap);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], $urandom_range(0, max_gap));
    exp_q.push_back(w);
  endtask

  task automatic pulse_start(input logic with_byte);
    @(negedge clk);
    start = 1'b1;
    if (with_byte) begin
      rx_valid = 1'b1;
      rx_data  = 8'hFF;
    end
    @(posedge clk);
    #1;
    start    = 1'b0;
    rx_valid = 1'b0;
  endtask

  task automatic verify_image(input int n);
    logic [31:0] exp;
    for (int i = 0; i < n; i++) begin
      pc  = AW'(i);
      #1;
      exp = exp_q.pop_front();
      check($sformatf("fetch_pc%0d", i), instr, exp);
    end
    if (n < 2**AW) begin
      pc = AW'(n);
      #1;
      check("fetch_past_end", instr, NOP);
    end
  endtask

  initial begin
    logic [31:0] w;

    // Reset state
    #12;
    check("rst_rx_ready", {31'd0, rx_ready}, 32'd0);
    check("rst_cpu_rst_n", {31'd0, cpu_rst_n}, 32'd0);
    check("rst_load_done", {31'd0, load_done}, 32'd0);
    check("rst_load_err", {31'd0, load_err}, 32'd0);
    check("rst_words_loaded", 32'(words_loaded), 32'd0);
    check("rst_instr", instr, NOP);
    @(negedge clk);
    rst_n = 1'b1;

    // 1: three-word image, DONE on the 16th byte edge
    pulse_start(1'b0);
    check("t1_hdr_rx_ready", {31'd0, rx_ready}, 32'd1);
    send_hdr(32'd3);
    send_word(32'h0050_0093, 0);
    send_word(32'h0010_0113, 0);
    w = 32'h0020_81B3;
    for (int i = 0; i < 3; i++) send_byte(w[8*i +: 8], 0);
    check("t1_cpu_rst_before", {31'd0, cpu_rst_n}, 32'd0);
    check("t1_instr_before_done", instr, NOP);
    send_byte(w[31:24], 0);
    exp_q.push_back(w);
    check("t1_cpu_rst_after", {31'd0, cpu_rst_n}, 32'd1);
    check("t1_load_done", {31'd0, load_done}, 32'd1);
    check("t1_words_loaded", 32'(words_loaded), 32'd3);
    check("t1_rx_ready_done", {31'd0, rx_ready}, 32'd0);
    verify_image(3);

    // 2: empty image
    pulse_start(1'b0);
    send_hdr(32'd0);
    check("t2_load_done", {31'd0, load_done}, 32'd1);
    check("t2_cpu_rst_n", {31'd0, cpu_rst_n}, 32'd1);
    check("t2_words_loaded", 32'(words_loaded), 32'd0);
    for (int i = 0; i < 2**AW; i += 5) begin
      pc = AW'(i);
      #1;
      check($sformatf("t2_nop_pc%0d", i), instr, NOP);
    end

    // 3: oversize header, then a full-depth image
    pulse_start(1'b0);
    send_hdr(32'd17);
    check("t3_load_err", {31'd0, load_err}, 32'd1);
    check("t3_cpu_rst_n", {31'd0, cpu_rst_n}, 32'd0);
    check("t3_rx_ready", {31'd0, rx_ready}, 32'd0);
    check("t3_load_done", {31'd0, load_done}, 32'd0);
    pulse_start(1'b0);
    check("t3_err_cleared", {31'd0, load_err}, 32'd0);
    send_hdr(32'd16);
    for (int i = 0; i < 16; i++) send_word($urandom, 0);
    check("t3_full_done", {31'd0, load_done}, 32'd1);
    check("t3_full_words", 32'(words_loaded), 32'd16);
    verify_image(16);

    // 4: gapped 2-word load with a start pulse mid-DATA
    pulse_start(1'b0);
    send_hdr(32'd2);
    send_word(32'hA5A5_0F0F, 5);
    pulse_start(1'b0);
    check("t4_start_ignored_ready", {31'd0, rx_ready}, 32'd1);
    check("t4_start_ignored_words", 32'(words_loaded), 32'd1);
    send_word(32'h1234_CAFE, 5);
    check("t4_load_done", {31'd0, load_done}, 32'd1);
    verify_image(2);

    // 5: async reset mid-load, then reload one word
    pulse_start(1'b0);
    send_hdr(32'd2);
    w = 32'h7766_5544;
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], 0);
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("t5_rst_rx_ready", {31'd0, rx_ready}, 32'd0);
    check("t5_rst_words", 32'(words_loaded), 32'd0);
    check("t5_rst_cpu_rst_n", {31'd0, cpu_rst_n}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    pulse_start(1'b0);
    send_hdr(32'd1);
    send_word(32'hDEAD_BEEF, 0);
    check("t5_load_done", {31'd0, load_done}, 32'd1);
    verify_image(1);

    // 6: restart from DONE with a coincident byte that must not be consumed
    pulse_start(1'b1);
    check("t6_cpu_rst_fall", {31'd0, cpu_rst_n}, 32'd0);
    check("t6_load_done_clr", {31'd0, load_done}, 32'd0);
    check("t6_words_clr", 32'(words_loaded), 32'd0);
    pc = '0;
    #1;
    check("t6_nop_in_hdr", instr, NOP);
    send_hdr(32'd1);
    check("t6_nop_in_data", instr, NOP);
    send_word(32'h1357_9BDF, 0);
    check("t6_cpu_rst_rise", {31'd0, cpu_rst_n}, 32'd1);
    verify_image(1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
